ama_pipe_adder: RTL

AMA_PIPE_ADDER -- requirements
Module: ama_pipe_adder

---
 rtl/ama_pkg.sv | 33 +++
 rtl/ama_seg_stage.sv | 95 +++++++++
 rtl/ama_pipe_adder.sv | 113 +++++++++++
 3 files changed

// File: rtl/ama_pkg.sv
// Shared types, default parameters and bit-cell functions for the
// approximate mirror-adder pipeline.
package ama_pkg;

  localparam int unsigned WIDTH_DEF    = 28;
  localparam int unsigned SEG_DEF      = 4;
  localparam int unsigned APPR_MAX_DEF = 7;
  localparam int unsigned ERRW_DEF     = 16;

  // One-bit adder cell result: carry out and sum bit.
  typedef struct packed {
    logic c;
    logic s;
  } cell_t;

  // Approximate cell: the carry is simply A, and the sum is a cheap
  // function that matches the exact sum only on some input patterns.
  function automatic cell_t approx_cell(input logic a, input logic b, input logic ci);
    cell_t r;
    r.c = a;
    r.s = (~a & (b | ci)) | (a & b & ci);
    return r;
  endfunction

  // Exact full-adder cell.
  function automatic cell_t exact_cell(input logic a, input logic b, input logic ci);
    cell_t r;
    r.s = a ^ b ^ ci;
    r.c = (a & b) | (a & ci) | (b & ci);
    return r;
  endfunction

endpackage

// File: rtl/ama_seg_stage.sv
// One pipeline stage: adds SEG bits starting at bit OFF, both with the
// mixed approximate/exact cells and with a fully exact reference chain,
// then registers results, carries and remaining operand bits.
module ama_seg_stage
  import ama_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned SEG   = SEG_DEF,
  parameter int unsigned AW    = 3,
  parameter int unsigned OFF   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             valid_in,
  input  logic [AW-1:0]    n_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
  input  logic             ec_in,
  input  logic [WIDTH-1:0] sum_in,
  input  logic [WIDTH-1:0] ex_in,
  output logic             valid_out,
  output logic [AW-1:0]    n_out,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic             c_out,
  output logic             ec_out,
  output logic [WIDTH-1:0] sum_out,
  output logic [WIDTH-1:0] ex_out
);

  // Operand bits at or below this segment are consumed; clearing them lets
  // synthesis drop those flops while the datapath keeps a uniform width.
  localparam logic [WIDTH-1:0] KEEP = ~((WIDTH'(1) << (OFF + SEG)) - WIDTH'(1));

  logic [SEG:0]   ac;
  logic [SEG:0]   xc;
  logic [SEG-1:0] seg_s;
  logic [SEG-1:0] seg_x;
  logic [WIDTH-1:0] sum_nxt;
  logic [WIDTH-1:0] ex_nxt;

  assign ac[0] = c_in;
  assign xc[0] = ec_in;

  for (genvar i = 0; i < SEG; i++) begin : g_bit
    cell_t appr_r;
    cell_t full_r;
    cell_t ref_r;
    logic  use_appr;

    assign use_appr = int'(n_in) > int'(OFF + i);
    assign appr_r   = approx_cell(a_in[OFF+i], b_in[OFF+i], ac[i]);
    assign full_r   = exact_cell(a_in[OFF+i], b_in[OFF+i], ac[i]);
    assign ref_r    = exact_cell(a_in[OFF+i], b_in[OFF+i], xc[i]);

    assign seg_s[i] = use_appr ? appr_r.s : full_r.s;
    assign ac[i+1]  = use_appr ? appr_r.c : full_r.c;
    assign seg_x[i] = ref_r.s;
    assign xc[i+1]  = ref_r.c;
  end

  // Merge this segment's sum bits into the partially built words.
  always_comb begin
    sum_nxt = sum_in;
    ex_nxt  = ex_in;
    sum_nxt[OFF +: SEG] = seg_s;
    ex_nxt[OFF +: SEG]  = seg_x;
  end

  // Stage registers; everything holds when the pipeline is stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_out <= 1'b0;
      n_out     <= '0;
      a_out     <= '0;
      b_out     <= '0;
      c_out     <= 1'b0;
      ec_out    <= 1'b0;
      sum_out   <= '0;
      ex_out    <= '0;
    end else if (en) begin
      valid_out <= valid_in;
      n_out     <= n_in;
      a_out     <= a_in & KEEP;
      b_out     <= b_in & KEEP;
      c_out     <= ac[SEG];
      ec_out    <= xc[SEG];
      sum_out   <= sum_nxt;
      ex_out    <= ex_nxt;
    end
  end

endmodule

// File: rtl/ama_pipe_adder.sv
// Pipelined approximate adder: the n lowest bits use approximate cells,
// the rest are exact; an exact reference sum travels alongside to flag
// and count erroneous results.
module ama_pipe_adder
  import ama_pkg::*;
#(
  parameter int unsigned WIDTH    = WIDTH_DEF,
  parameter int unsigned SEG      = SEG_DEF,
  parameter int unsigned APPR_MAX = APPR_MAX_DEF,
  parameter int unsigned ERRW     = ERRW_DEF,
  localparam int unsigned AW      = $clog2(APPR_MAX + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic [AW-1:0]    appr_bits,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             err,
  input  logic             err_clr,
  output logic [ERRW-1:0]  err_cnt
);

  localparam int unsigned NST = WIDTH / SEG;

  logic             adv;
  logic [AW-1:0]    n_lim;

  logic             v_c [NST+1];
  logic             c_c [NST+1];
  logic             e_c [NST+1];
  logic [AW-1:0]    n_c [NST+1];
  logic [WIDTH-1:0] a_c [NST+1];
  logic [WIDTH-1:0] b_c [NST+1];
  logic [WIDTH-1:0] s_c [NST+1];
  logic [WIDTH-1:0] x_c [NST+1];
  logic             unused_tail;

  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  // Clamp the requested approximate bit count to the supported maximum.
  always_comb begin
    n_lim = appr_bits;
    if (appr_bits > AW'(APPR_MAX)) begin
      n_lim = AW'(APPR_MAX);
    end
  end

  assign v_c[0] = in_valid;
  assign n_c[0] = n_lim;
  assign a_c[0] = A;
  assign b_c[0] = B;
  assign c_c[0] = Cin;
  assign e_c[0] = Cin;
  assign s_c[0] = '0;
  assign x_c[0] = '0;

  for (genvar k = 0; k < NST; k++) begin : g_stage
    ama_seg_stage #(
      .WIDTH (WIDTH),
      .SEG   (SEG),
      .AW    (AW),
      .OFF   (k * SEG)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (adv),
      .valid_in  (v_c[k]),
      .n_in      (n_c[k]),
      .a_in      (a_c[k]),
      .b_in      (b_c[k]),
      .c_in      (c_c[k]),
      .ec_in     (e_c[k]),
      .sum_in    (s_c[k]),
      .ex_in     (x_c[k]),
      .valid_out (v_c[k+1]),
      .n_out     (n_c[k+1]),
      .a_out     (a_c[k+1]),
      .b_out     (b_c[k+1]),
      .c_out     (c_c[k+1]),
      .ec_out    (e_c[k+1]),
      .sum_out   (s_c[k+1]),
      .ex_out    (x_c[k+1])
    );
  end

  // Operands and count leaving the last stage are fully consumed.
  assign unused_tail = ^{a_c[NST], b_c[NST], n_c[NST]};

  assign out_valid = v_c[NST];
  assign S         = s_c[NST];
  assign Cout      = c_c[NST];
  assign err       = v_c[NST] & ({c_c[NST], s_c[NST]} != {e_c[NST], x_c[NST]});

  // Saturating count of delivered erroneous results; clear has priority.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (err_clr) begin
      err_cnt <= '0;
    end else if (out_valid && out_ready && err && (err_cnt != '1)) begin
      err_cnt <= err_cnt + ERRW'(1);
    end
  end

endmodule
